spi_port_ctrl: RTL and testbench

Byte-wide SPI master for the Zorro-space SPI window of the accelerator CPLD, downstream of the address decoder/autoconfig stage that produces the SPI range select. Turns 68000 bus accesses in the window into register reads/writes, runs mode-0 SPI transfers on SPI_CS/SPI_SCK/SPI_MOSI/SPI_MISO, and returns a slow, synchronised, active-low DTACK to the CPU DTACK combiner.

---
 rtl/spi_port_pkg.sv | 34 +++
 rtl/spi_shift_engine.sv | 79 +++++++
 rtl/spi_port_ctrl.sv | 104 ++++++++++
 tb/tb_spi_port_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_port_pkg.sv
// Shared constants and state types for the Zorro-space SPI window:
// register map, CTRL/STATUS bit positions, FSM encodings and reset values.
package spi_port_pkg;

    localparam logic REG_DATA = 1'b0;
    localparam logic REG_CTRL = 1'b1;

    localparam int CTRL_CS_BIT     = 0;
    localparam int CTRL_DIV_LSB    = 1;
    localparam int STATUS_BUSY_BIT = 7;

    localparam logic [7:0] RX_RESET = 8'hFF;
    localparam logic [7:0] TX_RESET = 8'hFF;

    typedef enum logic [1:0] {
        B_IDLE,
        B_WAIT,
        B_ACK
    } bus_state_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LO,
        S_HI,
        S_DONE
    } shift_state_t;

    // S_DONE already counts as idle so a coinciding access is not stalled.
    function automatic logic engine_busy(shift_state_t s);
        return s inside {S_LOAD, S_LO, S_HI};
    endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// Mode-0, MSB-first byte shifter. The state output doubles as the busy source
// for the bus side and as a visible handle on the shift FSM.
module spi_shift_engine
    import spi_port_pkg::*;
#(
    parameter int DIV_WIDTH = 3
) (
    input  logic                 MB_CLK,
    input  logic                 RESET,
    input  logic                 start,
    input  logic [7:0]           tx_byte,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 miso,
    output shift_state_t         state,
    output logic                 sck,
    output logic                 mosi,
    output logic [7:0]           rx_byte
);

    shift_state_t         state_q, state_next;
    logic [DIV_WIDTH-1:0] phase_cnt;
    logic [2:0]           bit_cnt;
    logic [7:0]           tx_sr, rx_sr;
    logic                 enter_lo, enter_hi, hi_to_lo, hi_to_done;

    always_ff @(posedge MB_CLK or negedge RESET) begin
        if (!RESET) state_q <= S_IDLE;
        else        state_q <= state_next;
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            S_IDLE: if (start) state_next = S_LOAD;
            S_LOAD: state_next = S_LO;
            S_LO:   if (phase_cnt == '0) state_next = S_HI;
            S_HI:   if (phase_cnt == '0) state_next = (bit_cnt == 3'd7) ? S_DONE : S_LO;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        state = state_q;
        sck   = (state_q == S_HI);
        mosi  = tx_sr[7];
    end

    assign enter_lo   = (state_next == S_LO) && (state_q != S_LO);
    assign enter_hi   = (state_next == S_HI) && (state_q != S_HI);
    assign hi_to_lo   = (state_q == S_HI) && (state_next == S_LO);
    assign hi_to_done = (state_q == S_HI) && (state_next == S_DONE);

    // Each phase starts at div and ends at zero, giving div+1 cycles.
    always_ff @(posedge MB_CLK or negedge RESET) begin
        if (!RESET) begin
            phase_cnt <= '0;
            bit_cnt   <= '0;
        end else begin
            if (enter_lo || enter_hi)  phase_cnt <= div;
            else if (phase_cnt != '0)  phase_cnt <= phase_cnt - 1'b1;
            if (hi_to_lo || hi_to_done) bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge MB_CLK or negedge RESET) begin
        if (!RESET) begin
            tx_sr   <= TX_RESET;
            rx_sr   <= '0;
            rx_byte <= RX_RESET;
        end else begin
            if (state_q == S_IDLE && start) tx_sr <= tx_byte;
            else if (hi_to_lo)              tx_sr <= {tx_sr[6:0], 1'b1};
            if (enter_hi)   rx_sr   <= {rx_sr[6:0], miso};
            if (hi_to_done) rx_byte <= rx_sr;
        end
    end

endmodule

// File: rtl/spi_port_ctrl.sv
// SPI window register block: strobe synchroniser, bus handshake FSM,
// CTRL register and read mux in front of the shift engine.
module spi_port_ctrl
    import spi_port_pkg::*;
#(
    parameter int DIV_WIDTH   = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic       RESET,
    input  logic       MB_CLK,
    input  logic       SPI_SEL,
    input  logic       RW,
    input  logic       DS,
    input  logic       REG_ADDR,
    input  logic [7:0] DATA_IN,
    output logic [7:0] DATA_OUT,
    output logic       DATA_OE,
    output logic       SPI_DTACK,
    output logic       SPI_CS,
    output logic       SPI_SCK,
    output logic       SPI_MOSI,
    input  logic       SPI_MISO
);

    logic [SYNC_STAGES-1:0] sel_sync_q;
    logic                   sel_sync, access, busy, acked, do_op, ack_seen_q, start;
    logic [DIV_WIDTH:0]     ctrl_q;
    logic [7:0]             rx_byte, status;
    logic                   unused_data_bits;
    bus_state_t             bus_q, bus_next;
    shift_state_t           shift_state;

    always_ff @(posedge MB_CLK or negedge RESET) begin
        if (!RESET) sel_sync_q <= '0;
        else        sel_sync_q <= {sel_sync_q[SYNC_STAGES-2:0], SPI_SEL};
    end

    assign sel_sync = sel_sync_q[SYNC_STAGES-1];
    assign access   = sel_sync & ~DS;
    assign busy     = engine_busy(shift_state);

    always_ff @(posedge MB_CLK or negedge RESET) begin
        if (!RESET) begin
            bus_q      <= B_IDLE;
            ack_seen_q <= 1'b0;
        end else begin
            bus_q      <= bus_next;
            ack_seen_q <= (bus_q == B_ACK);
        end
    end

    // Only STATUS reads bypass the busy stall.
    always_comb begin
        bus_next = bus_q;
        case (bus_q)
            B_IDLE: if (access) bus_next = (busy && !(REG_ADDR == REG_CTRL && RW)) ? B_WAIT : B_ACK;
            B_WAIT: if (!access) bus_next = B_IDLE;
                    else if (!busy) bus_next = B_ACK;
            B_ACK:  if (!sel_sync) bus_next = B_IDLE;
            default: bus_next = B_IDLE;
        endcase
    end

    // Acknowledge drops with the synchronised strobe, a cycle before B_IDLE.
    always_comb begin
        acked     = (bus_q == B_ACK) && sel_sync;
        do_op     = (bus_q == B_ACK) && !ack_seen_q;
        SPI_DTACK = ~acked;
        DATA_OE   = acked & RW;
        start     = do_op && (REG_ADDR == REG_DATA) && !RW;
    end

    always_ff @(posedge MB_CLK or negedge RESET) begin
        if (!RESET)                                        ctrl_q <= '1;
        else if (do_op && (REG_ADDR == REG_CTRL) && !RW)   ctrl_q <= DATA_IN[DIV_WIDTH:0];
    end

    assign unused_data_bits = ^DATA_IN[7:DIV_WIDTH+1];
    assign SPI_CS = ctrl_q[CTRL_CS_BIT];

    always_comb begin
        status                  = '0;
        status[DIV_WIDTH:0]     = ctrl_q;
        status[STATUS_BUSY_BIT] = busy;
        DATA_OUT                = '0;
        if (DATA_OE) DATA_OUT = (REG_ADDR == REG_CTRL) ? status : rx_byte;
    end

    spi_shift_engine #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_engine (
        .MB_CLK (MB_CLK),
        .RESET  (RESET),
        .start  (start),
        .tx_byte(DATA_IN),
        .div    (ctrl_q[DIV_WIDTH:CTRL_DIV_LSB]),
        .miso   (SPI_MISO),
        .state  (shift_state),
        .sck    (SPI_SCK),
        .mosi   (SPI_MOSI),
        .rx_byte(rx_byte)
    );

endmodule

// File: tb/tb_spi_port_ctrl.sv
// Self-checking bench for spi_port_ctrl: bus cycles driven by tasks, SPI
// activity recorded by a monitor and compared with values derived from the register/timing rules.
module tb_spi_port_ctrl;

    logic       RESET, MB_CLK, SPI_SEL, RW, DS, REG_ADDR;
    logic [7:0] DATA_IN, DATA_OUT;
    logic       DATA_OE, SPI_DTACK, SPI_CS, SPI_SCK, SPI_MOSI, SPI_MISO;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int last_ack_cyc = 0;
    int dtack_lows = 0;

    logic       loop_mode = 1'b1;
    logic [7:0] slave_byte = 8'h00;
    logic [2:0] slave_idx = 3'd7;
    logic       sck_prev = 1'b0;
    int         rise_cyc[$];
    int         fall_cyc[$];
    logic       mosi_q[$];
    logic       cs_q[$];

    spi_port_ctrl #(.DIV_WIDTH(3), .SYNC_STAGES(2)) dut (
        .RESET(RESET), .MB_CLK(MB_CLK), .SPI_SEL(SPI_SEL), .RW(RW), .DS(DS),
        .REG_ADDR(REG_ADDR), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE),
        .SPI_DTACK(SPI_DTACK), .SPI_CS(SPI_CS), .SPI_SCK(SPI_SCK), .SPI_MOSI(SPI_MOSI),
        .SPI_MISO(SPI_MISO)
    );

    // Clock and cycle count
    initial MB_CLK = 1'b0;
    always #5 MB_CLK = ~MB_CLK;
    always @(posedge MB_CLK) cyc <= cyc + 1;

    // Slave: loopback, or a byte presented MSB first and advanced after each SCK fall.
    assign SPI_MISO = loop_mode ? SPI_MOSI : slave_byte[slave_idx];

    always @(negedge MB_CLK) begin
        if (SPI_SCK && !sck_prev) begin
            rise_cyc.push_back(cyc);
            mosi_q.push_back(SPI_MOSI);
            cs_q.push_back(SPI_CS);
        end
        if (!SPI_SCK && sck_prev) begin
            fall_cyc.push_back(cyc);
            slave_idx = slave_idx - 3'd1;
        end
        if (SPI_DTACK === 1'b0) dtack_lows++;
        sck_prev = SPI_SCK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1);
    end

    function automatic logic [7:0] mosi_byte(int first);
        logic [7:0] b = 'x;
        if (mosi_q.size() >= first + 8)
            for (int i = 0; i < 8; i++) b = {b[6:0], mosi_q[first + i]};
        return b;
    endfunction

    task automatic clear_mon();
        rise_cyc = {};
        fall_cyc = {};
        mosi_q   = {};
        cs_q     = {};
    endtask

    // Driver: one 68000-style access; latencies counted in MB_CLK edges, -1 if never seen.
    task automatic bus_cycle(input logic rw, input logic addr, input logic [7:0] wdata,
                             input int limit, output logic [7:0] rdata, output logic oe,
                             output int ack_lat, output int rel_lat, output logic rel_oe);
        ack_lat = -1; rel_lat = -1; rdata = 'x; oe = 1'bx; rel_oe = 1'bx;
        @(negedge MB_CLK);
        RW = rw; REG_ADDR = addr; DATA_IN = wdata; DS = 1'b0; SPI_SEL = 1'b1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge MB_CLK);
            if (SPI_DTACK === 1'b0) begin
                ack_lat = i; rdata = DATA_OUT; oe = DATA_OE; last_ack_cyc = cyc;
                break;
            end
        end
        SPI_SEL = 1'b0; DS = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge MB_CLK);
            if (SPI_DTACK === 1'b1) begin
                rel_lat = i; rel_oe = DATA_OE;
                break;
            end
        end
        @(negedge MB_CLK);
    endtask

    task automatic wait_falls(input int n, input int limit, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge MB_CLK);
            if (fall_cyc.size() >= n) begin ok = 1'b1; break; end
        end
        repeat (3) @(negedge MB_CLK);
    endtask

    task automatic test_reset();
        logic [7:0] rd; logic oe, roe; int al, rl;
        RESET = 1'b0; SPI_SEL = 1'b0; DS = 1'b1; RW = 1'b1; REG_ADDR = 1'b0; DATA_IN = 8'h00;
        repeat (3) @(negedge MB_CLK);
        n_total++;
        if ({SPI_CS, SPI_SCK, SPI_MOSI, SPI_DTACK, DATA_OE} !== 5'b10110)
            $display("FAIL reset_pins got cs/sck/mosi/dtack/oe=%b exp=10110",
                     {SPI_CS, SPI_SCK, SPI_MOSI, SPI_DTACK, DATA_OE});
        else n_pass++;
        n_total++;
        if (DATA_OUT !== 8'h00) $display("FAIL reset_data_out got=%h exp=00", DATA_OUT); else n_pass++;
        RESET = 1'b1;
        @(negedge MB_CLK);
        bus_cycle(1'b1, 1'b1, 8'h00, 20, rd, oe, al, rl, roe);
        n_total++;
        if (rd !== 8'h0F) $display("FAIL reset_status got=%h exp=0F", rd); else n_pass++;
        n_total++;
        if (al !== 3) $display("FAIL status_ack_latency got=%0d exp=3", al); else n_pass++;
        n_total++;
        if (oe !== 1'b1) $display("FAIL read_oe got=%b exp=1", oe); else n_pass++;
        n_total++;
        if (rl !== 2 || roe !== 1'b0) $display("FAIL release_latency got=%0d oe=%b exp=2 oe=0", rl, roe);
        else n_pass++;
        bus_cycle(1'b1, 1'b0, 8'h00, 20, rd, oe, al, rl, roe);
        n_total++;
        if (rd !== 8'hFF) $display("FAIL reset_rx got=%h exp=FF", rd); else n_pass++;
    endtask

    task automatic test_loopback_a5();
        logic [7:0] rd; logic oe, roe, ok; int al, rl, cs_ones;
        bus_cycle(1'b0, 1'b1, 8'h00, 20, rd, oe, al, rl, roe);
        n_total++;
        if (al !== 3 || oe !== 1'b0) $display("FAIL ctrl_write_ack got=%0d oe=%b exp=3 oe=0", al, oe);
        else n_pass++;
        loop_mode = 1'b1;
        clear_mon();
        bus_cycle(1'b0, 1'b0, 8'hA5, 20, rd, oe, al, rl, roe);
        n_total++;
        if (al !== 3) $display("FAIL data_write_ack got=%0d exp=3", al); else n_pass++;
        wait_falls(8, 200, ok);
        n_total++;
        if (ok !== 1'b1 || rise_cyc.size() !== 8)
            $display("FAIL a5_sck_pulses got=%0d exp=8", rise_cyc.size());
        else n_pass++;
        n_total++;
        if (mosi_byte(0) !== 8'hA5) $display("FAIL a5_mosi got=%h exp=A5", mosi_byte(0)); else n_pass++;
        cs_ones = 0;
        foreach (cs_q[i]) if (cs_q[i] !== 1'b0) cs_ones++;
        n_total++;
        if (cs_ones !== 0) $display("FAIL a5_cs_high_rises got=%0d exp=0", cs_ones); else n_pass++;
        for (int i = 1; i < rise_cyc.size(); i++) begin
            n_total++;
            if (rise_cyc[i] - rise_cyc[i-1] !== 2)
                $display("FAIL a5_period got=%0d exp=2", rise_cyc[i] - rise_cyc[i-1]);
            else n_pass++;
        end
        bus_cycle(1'b1, 1'b0, 8'h00, 20, rd, oe, al, rl, roe);
        n_total++;
        if (rd !== 8'hA5) $display("FAIL a5_rx got=%h exp=A5", rd); else n_pass++;
    endtask

    task automatic test_random_bytes();
        logic [7:0] rd, tx, sb, ctrl; logic oe, roe, ok, cs; int al, rl, dv, bad;
        for (int it = 0; it < 4; it++) begin
            dv = $urandom_range(0, 3);
            cs = 1'($urandom_range(0, 1));
            ctrl = 8'((dv << 1) | cs);
            tx = 8'($urandom);
            sb = 8'($urandom);
            bus_cycle(1'b0, 1'b1, ctrl, 20, rd, oe, al, rl, roe);
            loop_mode = 1'b0; slave_byte = sb; slave_idx = 3'd7;
            clear_mon();
            bus_cycle(1'b0, 1'b0, tx, 20, rd, oe, al, rl, roe);
            wait_falls(8, 16 * (dv + 1) + 40, ok);
            n_total++;
            if (ok !== 1'b1 || mosi_byte(0) !== tx)
                $display("FAIL rand_mosi got=%h exp=%h", mosi_byte(0), tx);
            else n_pass++;
            bad = 0;
            for (int i = 1; i < rise_cyc.size(); i++)
                if (rise_cyc[i] - rise_cyc[i-1] !== 2 * (dv + 1)) bad++;
            foreach (cs_q[i]) if (cs_q[i] !== cs) bad++;
            n_total++;
            if (bad !== 0 || rise_cyc.size() !== 8)
                $display("FAIL rand_sck_timing_cs bad=%0d rises=%0d exp bad=0 rises=8", bad, rise_cyc.size());
            else n_pass++;
            bus_cycle(1'b1, 1'b0, 8'h00, 20, rd, oe, al, rl, roe);
            n_total++;
            if (rd !== sb) $display("FAIL rand_rx got=%h exp=%h", rd, sb); else n_pass++;
            bus_cycle(1'b1, 1'b1, 8'h00, 20, rd, oe, al, rl, roe);
            n_total++;
            if (rd !== ctrl) $display("FAIL rand_status got=%h exp=%h", rd, ctrl); else n_pass++;
        end
        loop_mode = 1'b1;
    endtask

    task automatic test_slow_divider();
        logic [7:0] rd; logic oe, roe, ok; int al, rl, bad;
        bus_cycle(1'b0, 1'b1, 8'h0E, 20, rd, oe, al, rl, roe);
        clear_mon();
        bus_cycle(1'b0, 1'b0, 8'h3C, 20, rd, oe, al, rl, roe);
        wait_falls(8, 200, ok);
        bad = 0;
        for (int i = 1; i < rise_cyc.size(); i++)
            if (rise_cyc[i] - rise_cyc[i-1] !== 16) bad++;
        n_total++;
        if (ok !== 1'b1 || bad !== 0 || rise_cyc.size() !== 8)
            $display("FAIL slow_period bad=%0d rises=%0d exp bad=0 rises=8", bad, rise_cyc.size());
        else n_pass++;
        n_total++;
        if (fall_cyc.size() < 8 || fall_cyc[7] - rise_cyc[0] !== 120)
            $display("FAIL slow_active_span got=%0d exp=120", fall_cyc.size() < 8 ? -1 : fall_cyc[7] - rise_cyc[0]);
        else n_pass++;
        n_total++;
        if (mosi_byte(0) !== 8'h3C) $display("FAIL slow_mosi got=%h exp=3C", mosi_byte(0)); else n_pass++;
        bus_cycle(1'b1, 1'b1, 8'h00, 20, rd, oe, al, rl, roe);
        n_total++;
        if (rd !== 8'h0E) $display("FAIL slow_busy_clear got=%h exp=0E", rd); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd; logic oe, roe, ok; int al, rl, ack2;
        clear_mon();
        bus_cycle(1'b0, 1'b0, 8'hC3, 20, rd, oe, al, rl, roe);
        bus_cycle(1'b1, 1'b1, 8'h00, 20, rd, oe, al, rl, roe);
        n_total++;
        if (al !== 3 || rd !== 8'h8E) $display("FAIL busy_status got=%h lat=%0d exp=8E lat=3", rd, al);
        else n_pass++;
        bus_cycle(1'b0, 1'b0, 8'h69, 400, rd, oe, al, rl, roe);
        ack2 = last_ack_cyc;
        n_total++;
        if (al < 0 || fall_cyc.size() < 8 || ack2 !== fall_cyc[7] + 1)
            $display("FAIL stalled_ack got=%0d exp=%0d", ack2, fall_cyc.size() < 8 ? -1 : fall_cyc[7] + 1);
        else n_pass++;
        wait_falls(16, 300, ok);
        n_total++;
        if (ok !== 1'b1 || rise_cyc[8] - ack2 !== 10)
            $display("FAIL second_first_rise got=%0d exp=10", ok ? rise_cyc[8] - ack2 : -1);
        else n_pass++;
        n_total++;
        if (mosi_byte(0) !== 8'hC3 || mosi_byte(8) !== 8'h69)
            $display("FAIL b2b_mosi got=%h %h exp=C3 69", mosi_byte(0), mosi_byte(8));
        else n_pass++;
        bus_cycle(1'b1, 1'b0, 8'h00, 20, rd, oe, al, rl, roe);
        n_total++;
        if (rd !== 8'h69) $display("FAIL b2b_rx got=%h exp=69", rd); else n_pass++;
    endtask

    task automatic test_reset_mid_transfer();
        logic [7:0] rd; logic oe, roe; int al, rl;
        bus_cycle(1'b0, 1'b1, 8'h02, 20, rd, oe, al, rl, roe);
        clear_mon();
        bus_cycle(1'b0, 1'b0, 8'h5A, 20, rd, oe, al, rl, roe);
        for (int i = 0; i < 100; i++) begin
            if (rise_cyc.size() >= 4) break;
            @(negedge MB_CLK);
        end
        RESET = 1'b0;
        #1;
        n_total++;
        if ({SPI_SCK, SPI_CS, SPI_DTACK} !== 3'b011 || rise_cyc.size() !== 4)
            $display("FAIL reset_abort sck/cs/dtack=%b rises=%0d exp=011 rises=4",
                     {SPI_SCK, SPI_CS, SPI_DTACK}, rise_cyc.size());
        else n_pass++;
        repeat (2) @(negedge MB_CLK);
        RESET = 1'b1;
        repeat (20) @(negedge MB_CLK);
        n_total++;
        if (rise_cyc.size() !== 4) $display("FAIL reset_no_resume got=%0d exp=4", rise_cyc.size()); else n_pass++;
        bus_cycle(1'b1, 1'b1, 8'h00, 20, rd, oe, al, rl, roe);
        n_total++;
        if (rd !== 8'h0F) $display("FAIL reset_mid_status got=%h exp=0F", rd); else n_pass++;
        bus_cycle(1'b1, 1'b0, 8'h00, 20, rd, oe, al, rl, roe);
        n_total++;
        if (rd !== 8'hFF) $display("FAIL reset_mid_rx got=%h exp=FF", rd); else n_pass++;
    endtask

    task automatic test_withdraw();
        logic [7:0] rd; logic oe, roe, ok; int al, rl, d0;
        bus_cycle(1'b0, 1'b1, 8'h02, 20, rd, oe, al, rl, roe);
        clear_mon();
        bus_cycle(1'b0, 1'b0, 8'h96, 20, rd, oe, al, rl, roe);
        d0 = dtack_lows;
        bus_cycle(1'b0, 1'b0, 8'h11, 6, rd, oe, al, rl, roe);
        n_total++;
        if (al !== -1) $display("FAIL withdraw_ack got=%0d exp=-1", al); else n_pass++;
        wait_falls(8, 100, ok);
        repeat (40) @(negedge MB_CLK);
        n_total++;
        if (dtack_lows !== d0) $display("FAIL withdraw_dtack_low_cycles got=%0d exp=%0d", dtack_lows - d0, 0);
        else n_pass++;
        n_total++;
        if (ok !== 1'b1 || rise_cyc.size() !== 8 || mosi_byte(0) !== 8'h96)
            $display("FAIL withdraw_no_second rises=%0d mosi=%h exp rises=8 mosi=96", rise_cyc.size(), mosi_byte(0));
        else n_pass++;
        bus_cycle(1'b1, 1'b0, 8'h00, 20, rd, oe, al, rl, roe);
        n_total++;
        if (rd !== 8'h96) $display("FAIL withdraw_rx got=%h exp=96", rd); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_loopback_a5();
        test_random_bytes();
        test_slow_divider();
        test_back_to_back();
        test_reset_mid_transfer();
        test_withdraw();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
